// File: rtl/rally_referee.sv
// rally_referee
//   Referee for the two-player volley game. Turns the collision levels coming
//   from the ball controller into touch and ground events, enforces the
//   max-touches rule, decides who wins each rally, keeps the scores and the
//   serving side, and flags the end of the game.
//
// Ports
//   clk          pixel clock, all logic lives in this single domain
//   rst          synchronous active-high reset
//   pl1_col      player1/ball overlap level
//   pl2_col      player2/ball overlap level
//   gnd_col      ball-at-ground level
//   ball_posx    ball left X pixel
//   new_game     one-cycle restart request
//   ovr_touch    touch-limit fault back to the ball controller
//   pl1_score    player1 score
//   pl2_score    player2 score
//   serve_pl     serving player (0 = PL1, 1 = PL2)
//   point_pulse  one-cycle strobe per awarded point
//   point_winner winner of the last point, valid with point_pulse
//   game_over    high once a player reaches WIN_SCORE
module rally_referee #(
  parameter int MAX_TOUCH   = 3,
  parameter int WIN_SCORE   = 15,
  parameter int NET_X       = 512,
  parameter int BALL_HALF   = 32,
  parameter int TOUCH_GAP   = 16_250_000,
  parameter int OVR_HOLD    = 1_300_000,
  parameter int DEAD_CYCLES = 162_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pl1_col,
  input  logic        pl2_col,
  input  logic        gnd_col,
  input  logic [11:0] ball_posx,
  input  logic        new_game,
  output logic        ovr_touch,
  output logic [4:0]  pl1_score,
  output logic [4:0]  pl2_score,
  output logic        serve_pl,
  output logic        point_pulse,
  output logic        point_winner,
  output logic        game_over
);

  localparam int CW = $clog2(MAX_TOUCH + 2);
  localparam int GW = $clog2(TOUCH_GAP + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int OW = $clog2(OVR_HOLD + 1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_TOUCH);
  localparam logic [GW-1:0] GAP_MAX   = GW'(TOUCH_GAP);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [OW-1:0] OVR_LAST  = OW'(OVR_HOLD - 1);
  localparam logic [4:0]    WIN       = 5'(WIN_SCORE);
  localparam logic [12:0]   NET       = 13'(NET_X);
  localparam logic [12:0]   HALF      = 13'(BALL_HALF);

  localparam logic [2:0] S_SERVE = 3'd0;
  localparam logic [2:0] S_RALLY = 3'd1;
  localparam logic [2:0] S_POINT = 3'd2;
  localparam logic [2:0] S_DEAD  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic          pl1_q, pl2_q, gnd_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [DW-1:0] dead_q, dead_d;
  logic          ovr_q, ovr_d;
  logic [OW-1:0] ovr_cnt_q, ovr_cnt_d;
  logic          pend_q, pend_d;
  logic [4:0]    p1s_q, p1s_d, p2s_q, p2s_d;
  logic          serve_q, serve_d;
  logic          pulse_q, pulse_d;
  logic          winner_q, winner_d;
  logic          over_q, over_d;

  logic          p1_edge, p2_edge, gnd_edge;
  logic          touch_pl, touch_same, touch_ok;
  logic [CW-1:0] touch_count;
  logic [12:0]   ball_centre;
  logic          gnd_winner;
  logic [4:0]    award_score;

  assign p1_edge  = pl1_col & ~pl1_q;
  assign p2_edge  = pl2_col & ~pl2_q;
  assign gnd_edge = gnd_col & ~gnd_q;

  // PL1 wins a simultaneous edge; the PL2 edge is simply dropped.
  assign touch_pl    = ~p1_edge;
  assign touch_same  = (touch_pl == last_q);
  assign touch_ok    = (p1_edge | p2_edge) & (~touch_same | (gap_q == GAP_MAX));
  assign touch_count = touch_same ? count_q + CW'(1) : CW'(1);

  // Ball landed on PL1's half (left of the net) -> PL2 takes the point.
  assign ball_centre = {1'b0, ball_posx} + HALF;
  assign gnd_winner  = (ball_centre < NET);

  assign award_score = pend_q ? p2s_q + 5'd1 : p1s_q + 5'd1;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    last_d    = last_q;
    gap_d     = (gap_q == GAP_MAX) ? gap_q : gap_q + GW'(1);
    dead_d    = dead_q;
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    pend_d    = pend_q;
    p1s_d     = p1s_q;
    p2s_d     = p2s_q;
    serve_d   = serve_q;
    pulse_d   = 1'b0;
    winner_d  = winner_q;
    over_d    = over_q;

    // Fault hold runs on its own, regardless of the rally state.
    if (ovr_q) begin
      if (ovr_cnt_q == OVR_LAST) begin
        ovr_d     = 1'b0;
        ovr_cnt_d = '0;
      end else begin
        ovr_cnt_d = ovr_cnt_q + OW'(1);
      end
    end

    case (state_q)
      S_SERVE: begin
        if (touch_ok) begin
          state_d = S_RALLY;
          count_d = CW'(1);
          last_d  = touch_pl;
          gap_d   = '0;
        end
      end
      S_RALLY: begin
        // A ground hit ends the rally even if a touch arrives in the same cycle.
        if (gnd_edge) begin
          state_d = S_POINT;
          pend_d  = gnd_winner;
        end else if (touch_ok) begin
          count_d = touch_count;
          last_d  = touch_pl;
          gap_d   = '0;
          if (touch_count > CNT_MAX) begin
            state_d   = S_POINT;
            pend_d    = ~touch_pl;
            ovr_d     = 1'b1;
            ovr_cnt_d = '0;
          end
        end
      end
      S_POINT: begin
        if (pend_q) p2s_d = award_score;
        else        p1s_d = award_score;
        serve_d  = pend_q;
        pulse_d  = 1'b1;
        winner_d = pend_q;
        count_d  = '0;
        dead_d   = '0;
        if (award_score == WIN) begin
          state_d = S_OVER;
          over_d  = 1'b1;
        end else begin
          state_d = S_DEAD;
        end
      end
      S_DEAD: begin
        if (dead_q == DEAD_LAST) state_d = S_SERVE;
        else                     dead_d  = dead_q + DW'(1);
      end
      S_OVER: begin
      end
      default: state_d = S_SERVE;
    endcase

    // Restart overrides anything decided above in the same cycle.
    if (new_game) begin
      state_d   = S_SERVE;
      p1s_d     = '0;
      p2s_d     = '0;
      serve_d   = 1'b0;
      over_d    = 1'b0;
      count_d   = '0;
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
      gap_d     = '0;
      dead_d    = '0;
      pulse_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pl1_q     <= 1'b0;
      pl2_q     <= 1'b0;
      gnd_q     <= 1'b0;
      state_q   <= S_SERVE;
      count_q   <= '0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      dead_q    <= '0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
      pend_q    <= 1'b0;
      p1s_q     <= '0;
      p2s_q     <= '0;
      serve_q   <= 1'b0;
      pulse_q   <= 1'b0;
      winner_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      pl1_q     <= pl1_col;
      pl2_q     <= pl2_col;
      gnd_q     <= gnd_col;
      state_q   <= state_d;
      count_q   <= count_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      dead_q    <= dead_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
      pend_q    <= pend_d;
      p1s_q     <= p1s_d;
      p2s_q     <= p2s_d;
      serve_q   <= serve_d;
      pulse_q   <= pulse_d;
      winner_q  <= winner_d;
      over_q    <= over_d;
    end
  end

  assign ovr_touch    = ovr_q;
  assign pl1_score    = p1s_q;
  assign pl2_score    = p2s_q;
  assign serve_pl     = serve_q;
  assign point_pulse  = pulse_q;
  assign point_winner = winner_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_rally_referee.sv
// Testbench for rally_referee: directed scenarios followed by random play,
// checked by a scoreboard fed from a timestamp-based model of the game rules.
module tb_rally_referee;

  localparam int MAX_TOUCH = 3;
  localparam int WIN_SCORE = 3;
  localparam int NET_X     = 512;
  localparam int BALL_HALF = 32;
  localparam int TOUCH_GAP = 4;
  localparam int OVR_HOLD  = 8;
  localparam int DEAD_CYC  = 20;

  logic        clk, rst, pl1_col, pl2_col, gnd_col, new_game;
  logic [11:0] ball_posx;
  logic        ovr_touch, serve_pl, point_pulse, point_winner, game_over;
  logic [4:0]  pl1_score, pl2_score;

  rally_referee #(
    .MAX_TOUCH(MAX_TOUCH), .WIN_SCORE(WIN_SCORE), .NET_X(NET_X),
    .BALL_HALF(BALL_HALF), .TOUCH_GAP(TOUCH_GAP), .OVR_HOLD(OVR_HOLD),
    .DEAD_CYCLES(DEAD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .pl1_col(pl1_col), .pl2_col(pl2_col),
    .gnd_col(gnd_col), .ball_posx(ball_posx), .new_game(new_game),
    .ovr_touch(ovr_touch), .pl1_score(pl1_score), .pl2_score(pl2_score),
    .serve_pl(serve_pl), .point_pulse(point_pulse),
    .point_winner(point_winner), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct {
    int ev; int w; int s1; int s2; int sv; int ov;
  } pt_t;
  pt_t exp_pt[$];
  int  exp_ovr[$];

  // ---------------- reference model ----------------
  // Time-stamp view of the rules: who touched last and when, the first
  // cycle at which collisions count again, and the running score.
  bit m_p1_prev, m_p2_prev, m_g_prev;
  int m_s1, m_s2, m_serve;
  bit m_done, m_play;
  int m_count, m_last, m_la, m_blocked, m_done_ev;

  task automatic award(int e, int w);
    if (w == 1) m_s2++; else m_s1++;
    m_serve = w;
    m_play  = 0;
    m_count = 0;
    if ((w == 1 ? m_s2 : m_s1) == WIN_SCORE) begin
      m_done = 1;
      m_done_ev = e;
    end else begin
      m_blocked = e + 2 + DEAD_CYC;
    end
    exp_pt.push_back('{e + 1, w, m_s1, m_s2, m_serve, int'(m_done)});
  endtask

  task automatic model_eval(int e, bit r, bit p1, bit p2, bit g, int x, bit ng);
    bit e1, e2, eg, same;
    int pl;
    e1 = p1 && !m_p1_prev;
    e2 = p2 && !m_p2_prev;
    eg = g && !m_g_prev;
    m_p1_prev = r ? 1'b0 : p1;
    m_p2_prev = r ? 1'b0 : p2;
    m_g_prev  = r ? 1'b0 : g;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_serve = 0; m_done = 0; m_play = 0;
      m_count = 0; m_last = 0; m_la = e; m_blocked = 0;
      return;
    end
    if (ng) begin
      m_s1 = 0; m_s2 = 0; m_serve = 0; m_done = 0; m_play = 0;
      m_count = 0; m_la = e; m_blocked = 0;
      return;
    end
    if (m_done || e < m_blocked) return;
    if (m_play && eg) begin
      award(e, (x + BALL_HALF < NET_X) ? 1 : 0);
      return;
    end
    if (e1 || e2) begin
      pl = e1 ? 0 : 1;
      same = (pl == m_last);
      if (same && (e - m_la - 1 < TOUCH_GAP)) return;
      m_la = e;
      if (same) m_count++;
      else begin
        m_count = 1;
        m_last = pl;
      end
      if (!m_play) begin
        m_play = 1;
        m_count = 1;
      end else if (m_count > MAX_TOUCH) begin
        exp_ovr.push_back(e);
        award(e, 1 - pl);
      end
    end
  endtask

  // ---------------- driver ----------------
  bit cur_rst, cur_p1, cur_p2, cur_g, cur_ng;
  int cur_x;

  task automatic tick();
    @(negedge clk);
    rst = cur_rst; pl1_col = cur_p1; pl2_col = cur_p2; gnd_col = cur_g;
    new_game = cur_ng; ball_posx = 12'(cur_x);
    model_eval(cyc + 1, cur_rst, cur_p1, cur_p2, cur_g, cur_x, cur_ng);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic hit_p1();
    cur_p1 = 1; tick(); cur_p1 = 0; tick();
  endtask

  task automatic hit_p2();
    cur_p2 = 1; tick(); cur_p2 = 0; tick();
  endtask

  task automatic hit_gnd(int x);
    cur_x = x; cur_g = 1; tick(); cur_g = 0; tick();
  endtask

  // ---------------- monitor ----------------
  bit mon_en = 0;
  bit ovr_prev = 0;
  int ovr_len = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_pt.size() > 0 && exp_pt[0].ev < cyc) begin
        chk("point_missed", 0, 1);
        void'(exp_pt.pop_front());
      end
      if (point_pulse) begin
        if (exp_pt.size() == 0 || exp_pt[0].ev != cyc) begin
          chk("point_unexpected", 1, 0);
        end else begin
          pt_t p;
          p = exp_pt.pop_front();
          $display("point @%0d winner=%0d score=%0d:%0d serve=%0d over=%0d",
                   cyc, point_winner, pl1_score, pl2_score, serve_pl, game_over);
          chk("point_winner", int'(point_winner), p.w);
          chk("pl1_score", int'(pl1_score), p.s1);
          chk("pl2_score", int'(pl2_score), p.s2);
          chk("serve_pl", int'(serve_pl), p.sv);
          chk("game_over", int'(game_over), p.ov);
        end
      end
      if (exp_ovr.size() > 0 && exp_ovr[0] < cyc && !(ovr_touch && !ovr_prev)) begin
        chk("ovr_missed", 0, 1);
        void'(exp_ovr.pop_front());
      end
      if (ovr_touch && !ovr_prev) begin
        if (exp_ovr.size() == 0) chk("ovr_unexpected", 1, 0);
        else chk("ovr_start_cyc", cyc, exp_ovr.pop_front());
        ovr_len = 1;
      end else if (ovr_touch) begin
        ovr_len++;
      end else if (ovr_prev) begin
        chk("ovr_len", ovr_len, OVR_HOLD);
      end
      ovr_prev = ovr_touch;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cur_rst = 1; cur_p1 = 0; cur_p2 = 0; cur_g = 0; cur_ng = 0; cur_x = 0;
    idle(3);
    cur_rst = 0;
    tick();
    chk("rst_pl1_score", int'(pl1_score), 0);
    chk("rst_pl2_score", int'(pl2_score), 0);
    chk("rst_serve", int'(serve_pl), 0);
    chk("rst_pulse", int'(point_pulse), 0);
    chk("rst_ovr", int'(ovr_touch), 0);
    chk("rst_over", int'(game_over), 0);
    mon_en = 1;
    idle(8);

    // one long PL1 contact counts as one touch
    cur_p1 = 1; idle(3); cur_p1 = 0; idle(6);
    chk("touch_no_pulse", int'(point_pulse), 0);
    chk("touch_pl2_score", int'(pl2_score), 0);

    // ground on PL1 side -> PL2 point, then PL1 edges during dead time
    hit_gnd(400);
    repeat (10) hit_p1();
    idle(10);

    // four PL1 touches 6 apart -> fault
    repeat (4) begin
      cur_p1 = 1; tick(); cur_p1 = 0; idle(5);
    end
    idle(25);
    // four PL1 edges 2 apart -> only the first counts
    repeat (4) hit_p1();
    chk("fast_no_ovr", int'(ovr_touch), 0);

    // alternating touches, then ground exactly at the net boundary
    hit_p2();
    hit_p1();
    hit_gnd(480);
    idle(25);

    // ground and PL2 edge together
    hit_p1();
    idle(5);
    cur_x = 700; cur_g = 1; cur_p2 = 1; tick();
    cur_g = 0; cur_p2 = 0; tick();
    idle(25);

    // PL1 reaches WIN_SCORE
    hit_p1();
    idle(5);
    hit_gnd(700);
    repeat (3) begin hit_p1(); hit_gnd(100); end
    idle(12);
    chk("over_held", int'(game_over), 1);
    chk("over_pl1", int'(pl1_score), WIN_SCORE);
    cur_ng = 1; tick(); cur_ng = 0; tick();
    chk("ng_pl1_score", int'(pl1_score), 0);
    chk("ng_pl2_score", int'(pl2_score), 0);
    chk("ng_serve", int'(serve_pl), 0);
    chk("ng_over", int'(game_over), 0);
    idle(6);

    // random play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) cur_p1 = ~cur_p1;
      if ($urandom_range(0, 4) == 0) cur_p2 = ~cur_p2;
      if ($urandom_range(0, 7) == 0) cur_g = ~cur_g;
      if ($urandom_range(0, 3) == 0) cur_x = 479 + $urandom_range(0, 2);
      else cur_x = $urandom_range(0, 1023);
      cur_ng = (m_done && (cyc + 1 - m_done_ev > 12) && $urandom_range(0, 3) == 0);
      tick();
    end
    cur_p1 = 0; cur_p2 = 0; cur_g = 0; cur_ng = 0;
    idle(40);
    chk("pending_points", exp_pt.size(), 0);
    chk("pending_ovr", exp_ovr.size(), 0);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
